// File: rtl/packed_struct_pkg.sv
// Shared types and frame constants for the packed-struct serial link.
// Build option: STRUCT_PARITY_EN appends an even-parity bit to every frame.
package packed_struct_pkg;

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } packed_struct_t;

  localparam int FIELD_CNT = 3;

`ifdef STRUCT_PARITY_EN
  localparam int FRAME_BITS = FIELD_CNT + 1;
`else
  localparam int FRAME_BITS = FIELD_CNT;
`endif

  // Wide enough to hold 0..FRAME_BITS in either build.
  localparam int BIT_CNT_W = 3;

  function automatic logic even_parity(input packed_struct_t f);
    return f.x ^ f.y ^ f.z;
  endfunction

endpackage

// File: rtl/struct_fifo.sv
// Small synchronous FIFO of packed_struct_t frames with occupancy count.
// Push while full and pop while empty are ignored.
module struct_fifo
  import packed_struct_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [FIELD_CNT-1:0] push_data,
  input  logic                 pop,
  output logic [FIELD_CNT-1:0] pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
);

  packed_struct_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Empty reads return zero so the consumer never sees stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= packed_struct_t'(push_data);
  end

endmodule

// File: rtl/packed_struct_deserializer.sv
// Receive side of the packed-struct link: serial bits -> {x,y,z} frames -> FIFO.
// Build option: STRUCT_PARITY_EN adds a 4th even-parity bit checked per frame.
module packed_struct_deserializer
  import packed_struct_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin_valid,
  input  logic                 sin_data,
  input  logic                 sin_sync,
  output logic                 sin_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FIELD_CNT-1:0] out_frame,
  output logic [CNT_W-1:0]     count,
  output logic                 err
);

  logic                  ready_en;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAME_BITS-2:0] sr;
  logic                  accept;
  logic                  full;
  logic                  empty;
  logic                  frame_done;
  logic                  parity_ok;
  logic                  push;
  logic                  fault;
  packed_struct_t        assembled;

  assign accept    = sin_valid && sin_ready;
  assign sin_ready = ready_en && !full;
  assign out_valid = !empty;

  // The last accepted bit completes the frame combinationally so it is
  // written on the same edge it arrives.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    frame_done = 1'b0;
    push       = 1'b0;
    fault      = 1'b0;
`ifdef STRUCT_PARITY_EN
    assembled = packed_struct_t'(sr);
    parity_ok = (even_parity(assembled) == sin_data);
`else
    assembled = packed_struct_t'({sr, sin_data});
    parity_ok = 1'b1;
`endif
    if (accept) begin
      if (sin_sync) begin
        fault = (bit_cnt != '0);
      end else if (bit_cnt == '0) begin
        fault = 1'b1;
      end else if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
        frame_done = 1'b1;
        push       = parity_ok;
        fault      = !parity_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      bit_cnt  <= '0;
      sr       <= '0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      err      <= fault;
      if (accept) begin
        sr <= {sr[FRAME_BITS-3:0], sin_data};
        if (sin_sync)
          bit_cnt <= BIT_CNT_W'(1);
        else if (frame_done)
          bit_cnt <= '0;
        else if (bit_cnt != '0)
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  struct_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (assembled),
    .pop       (out_ready),
    .pop_data  (out_frame),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_packed_struct_deserializer.sv
// Directed self-checking bench for packed_struct_deserializer (DEPTH=4).
// Parity scenario is compiled in when STRUCT_PARITY_EN is defined.
module tb_packed_struct_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin_valid, sin_data, sin_sync, sin_ready;
  logic       out_valid, out_ready;
  logic [2:0] out_frame;
  logic [2:0] count;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packed_struct_deserializer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .sin_sync  (sin_sync),
    .sin_ready (sin_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .count     (count),
    .err       (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic d);
    sin_valid = 1'b1;
    sin_sync  = s;
    sin_data  = d;
    step();
    sin_valid = 1'b0;
    sin_sync  = 1'b0;
  endtask

  // Sends a parity bit only in the parity build.
  task automatic send_parity(input logic [2:0] f);
`ifdef STRUCT_PARITY_EN
    send_bit(1'b0, ^f);
`else
    if (f === 3'bxxx) send_bit(1'b0, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [2:0] f);
    send_bit(1'b1, f[2]);
    send_bit(1'b0, f[1]);
    send_bit(1'b0, f[0]);
    send_parity(f);
  endtask

  task automatic pop_expect(input string tag, input logic [2:0] f);
    check({tag, "_valid"}, 8'(out_valid), 8'd1);
    check({tag, "_frame"}, 8'(out_frame), 8'(f));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; sin_sync = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    step();
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_count",     8'(count),     8'd0);
    check("rst_err",       8'(err),       8'd0);
    check("rst_sin_ready", 8'(sin_ready), 8'd0);
    check("rst_out_frame", 8'(out_frame), 8'd0);
    rst_n = 1'b1;
    check("rel_sin_ready_low", 8'(sin_ready), 8'd0);
    step();
    check("rel_sin_ready_high", 8'(sin_ready), 8'd1);

    // Scenario 1: single frame 1,0,1
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("s1_not_yet_valid", 8'(out_valid), 8'd0);
    send_bit(1'b0, 1'b1);
`ifdef STRUCT_PARITY_EN
    check("s1_wait_parity", 8'(out_valid), 8'd0);
    send_bit(1'b0, 1'b0);
`endif
    check("s1_count", 8'(count), 8'd1);
    check("s1_err",   8'(err),   8'd0);
    pop_expect("s1", 3'b101);
    check("s1_count_after_pop", 8'(count), 8'd0);
    check("s1_valid_after_pop", 8'(out_valid), 8'd0);

    // Scenario 2: fill to DEPTH, stall, pop one, accept the 5th, order kept
    send_frame(3'b001);
    send_frame(3'b010);
    send_frame(3'b011);
    check("s2_ready_at_3", 8'(sin_ready), 8'd1);
    send_frame(3'b100);
    check("s2_full_count", 8'(count),     8'd4);
    check("s2_full_ready", 8'(sin_ready), 8'd0);
    sin_valid = 1'b1; sin_sync = 1'b1; sin_data = 1'b1;
    step();
    sin_valid = 1'b0; sin_sync = 1'b0;
    check("s2_stall_count", 8'(count), 8'd4);
    check("s2_stall_err",   8'(err),   8'd0);
    check("s2_stable_frame", 8'(out_frame), 8'd1);
    pop_expect("s2_pop1", 3'b001);
    check("s2_ready_after_pop", 8'(sin_ready), 8'd1);
    check("s2_count_after_pop", 8'(count),     8'd3);
    send_frame(3'b111);
    check("s2_count_refill", 8'(count), 8'd4);
    pop_expect("s2_pop2", 3'b010);
    pop_expect("s2_pop3", 3'b011);
    pop_expect("s2_pop4", 3'b100);
    pop_expect("s2_pop5", 3'b111);
    check("s2_drained", 8'(count), 8'd0);

    // Scenario 3: resync discards a partial frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("s3_no_err_yet", 8'(err), 8'd0);
    send_bit(1'b1, 1'b1);
    check("s3_err_pulse", 8'(err), 8'd1);
    send_bit(1'b0, 1'b1);
    check("s3_err_cleared", 8'(err), 8'd0);
    send_bit(1'b0, 1'b0);
`ifdef STRUCT_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    check("s3_count", 8'(count), 8'd1);
    pop_expect("s3", 3'b110);
    check("s3_count_after_pop", 8'(count), 8'd0);

    // Scenario 4: out-of-frame bits
    send_bit(1'b0, 1'b1);
    check("s4_err_b0", 8'(err), 8'd1);
    send_bit(1'b0, 1'b0);
    check("s4_err_b1", 8'(err), 8'd1);
    send_bit(1'b0, 1'b1);
    check("s4_err_b2", 8'(err), 8'd1);
    check("s4_count",  8'(count), 8'd0);
    step();
    check("s4_err_idle", 8'(err), 8'd0);

    // Scenario 5: reset with two frames buffered and a partial in flight
    send_frame(3'b010);
    send_frame(3'b101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("s5_count_before", 8'(count), 8'd2);
    rst_n = 1'b0;
    #1;
    check("s5_valid_at_once", 8'(out_valid), 8'd0);
    check("s5_count_at_once", 8'(count),     8'd0);
    check("s5_ready_at_once", 8'(sin_ready), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    check("s5_ready_again", 8'(sin_ready), 8'd1);
    send_frame(3'b011);
    check("s5_err",   8'(err),   8'd0);
    check("s5_count", 8'(count), 8'd1);
    pop_expect("s5", 3'b011);

`ifdef STRUCT_PARITY_EN
    // Scenario 6: parity good then bad
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("s6_good_err", 8'(err), 8'd0);
    pop_expect("s6_good", 3'b110);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    check("s6_bad_err",   8'(err),       8'd1);
    check("s6_bad_count", 8'(count),     8'd0);
    check("s6_bad_valid", 8'(out_valid), 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
